// File: rtl/tag_free_list_pkg.sv
// rtl/tag_free_list_pkg.sv - shared tag types, sizing and helpers for the physical-tag free list
package tag_free_list_pkg;

   localparam int TAG_SIZE   = 7;
   localparam int TAG_IDX_W  = TAG_SIZE - 1;
   localparam int NUM_TAGS   = 1 << TAG_IDX_W;
   localparam int NUM_ISSUE  = 4;
   localparam int NUM_COMMIT = 4;

   typedef logic [TAG_SIZE-1:0] tag_t;
   typedef logic [NUM_TAGS-1:0] tag_map_t;

   // MSB set marks a special/immediate tag; these never enter the bitmaps
   localparam tag_t TAG_ZERO = {1'b1, {TAG_IDX_W{1'b0}}};

   localparam int   CNT_MAX        = (1 << TAG_SIZE) - 1;
   localparam tag_t FREE_CNT_RESET = tag_t'((NUM_TAGS > CNT_MAX) ? CNT_MAX : NUM_TAGS);

   function automatic logic is_special(tag_t t);
      return t[TAG_SIZE-1];
   endfunction

   function automatic tag_t popcount_sat(tag_map_t m);
      int c;
      c = 0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         c = c + int'(m[i]);
      end
      if (c > CNT_MAX) begin
         c = CNT_MAX;
      end
      return tag_t'(c);
   endfunction

endpackage

// File: rtl/tag_free_list_if.sv
// rtl/tag_free_list_if.sv - rename/commit side bundle of the physical-tag free list
interface tag_free_list_if;
   import tag_free_list_pkg::*;

   logic                  IN_mispred;
   logic                  IN_mispredFlush;
   logic [NUM_ISSUE-1:0]  IN_issueReq;
   logic [NUM_ISSUE-1:0]  OUT_issueValid;
   tag_t [NUM_ISSUE-1:0]  OUT_issueTags;
   logic [NUM_COMMIT-1:0] IN_commitValid;
   tag_t [NUM_COMMIT-1:0] IN_commitTags;
   tag_t [NUM_COMMIT-1:0] IN_commitPrevTags;
   tag_t                  OUT_freeCount;
   logic                  OUT_err;

   modport master (
      output IN_mispred, IN_mispredFlush, IN_issueReq,
             IN_commitValid, IN_commitTags, IN_commitPrevTags,
      input  OUT_issueValid, OUT_issueTags, OUT_freeCount, OUT_err
   );

   modport slave (
      input  IN_mispred, IN_mispredFlush, IN_issueReq,
             IN_commitValid, IN_commitTags, IN_commitPrevTags,
      output OUT_issueValid, OUT_issueTags, OUT_freeCount, OUT_err
   );

endinterface

// File: rtl/tag_prio_enc.sv
// rtl/tag_prio_enc.sv - returns the first NUM_OUT set-bit indices of a vector, lowest index first
module tag_prio_enc
   import tag_free_list_pkg::*;
#(
   parameter int WIDTH   = NUM_TAGS,
   parameter int NUM_OUT = NUM_ISSUE,
   parameter int IDX_W   = TAG_IDX_W
) (
   input  logic [WIDTH-1:0]              vec,
   output logic [NUM_OUT-1:0][IDX_W-1:0] idx,
   output logic [NUM_OUT-1:0]            valid
);

   always_comb begin
      int found;
      found = 0;
      idx   = '0;
      valid = '0;
      for (int t = 0; t < WIDTH; t++) begin
         if (vec[t]) begin
            for (int k = 0; k < NUM_OUT; k++) begin
               if (found == k) begin
                  idx[k]   = IDX_W'(t);
                  valid[k] = 1'b1;
               end
            end
            found = found + 1;
         end
      end
   end

endmodule

// File: rtl/tag_free_list.sv
// rtl/tag_free_list.sv - speculative/committed physical-tag free list feeding rename
// Optional integrity checking (sticky OUT_err plus assertions) under TAG_FREE_CHECK_EN.
module tag_free_list
   import tag_free_list_pkg::*;
(
   input logic           clk,
   input logic           rst,
   tag_free_list_if.slave bus
);

   tag_map_t spec_free;
   tag_map_t com_free;
   tag_map_t spec_n;
   tag_map_t com_n;
   tag_t     free_cnt;

   logic [NUM_ISSUE-1:0][TAG_IDX_W-1:0] offer_idx;
   logic [NUM_ISSUE-1:0]                offer_valid;
   logic [NUM_ISSUE-1:0]                take;
   logic                                commit_en;
   logic                                replay_en;

   tag_prio_enc #(
      .WIDTH   (NUM_TAGS),
      .NUM_OUT (NUM_ISSUE),
      .IDX_W   (TAG_IDX_W)
   ) u_enc (
      .vec   (spec_free),
      .idx   (offer_idx),
      .valid (offer_valid)
   );

   always_comb begin
      bus.OUT_issueValid = offer_valid;
      bus.OUT_issueTags  = '0;
      for (int i = 0; i < NUM_ISSUE; i++) begin
         if (offer_valid[i]) begin
            bus.OUT_issueTags[i] = {1'b0, offer_idx[i]};
         end
      end
   end

   assign commit_en = !bus.IN_mispredFlush;
   assign replay_en = bus.IN_mispredFlush && !bus.IN_mispred;
   assign take      = bus.IN_issueReq & offer_valid & {NUM_ISSUE{!bus.IN_mispred}};

   // Committed map first, since a mispredict restores from it including this cycle's commits
   always_comb begin
      com_n = com_free;
      if (commit_en) begin
         for (int s = 0; s < NUM_COMMIT; s++) begin
            if (bus.IN_commitValid[s]) begin
               if (!is_special(bus.IN_commitTags[s])) begin
                  com_n[bus.IN_commitTags[s][TAG_IDX_W-1:0]] = 1'b0;
               end
               if (!is_special(bus.IN_commitPrevTags[s])) begin
                  com_n[bus.IN_commitPrevTags[s][TAG_IDX_W-1:0]] = 1'b1;
               end
            end
         end
      end
   end

   // Lowest precedence applied first: issue/replay clears, then commit frees, then restore
   always_comb begin
      spec_n = spec_free;
      for (int i = 0; i < NUM_ISSUE; i++) begin
         if (take[i]) begin
            spec_n[offer_idx[i]] = 1'b0;
         end
      end
      if (replay_en) begin
         for (int s = 0; s < NUM_COMMIT; s++) begin
            if (bus.IN_commitValid[s] && !is_special(bus.IN_commitTags[s])) begin
               spec_n[bus.IN_commitTags[s][TAG_IDX_W-1:0]] = 1'b0;
            end
         end
      end
      if (commit_en) begin
         for (int s = 0; s < NUM_COMMIT; s++) begin
            if (bus.IN_commitValid[s] && !is_special(bus.IN_commitPrevTags[s])) begin
               spec_n[bus.IN_commitPrevTags[s][TAG_IDX_W-1:0]] = 1'b1;
            end
         end
      end
      if (bus.IN_mispred) begin
         spec_n = com_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_free <= '1;
         com_free  <= '1;
         free_cnt  <= FREE_CNT_RESET;
      end else begin
         spec_free <= spec_n;
         com_free  <= com_n;
         free_cnt  <= popcount_sat(spec_n);
      end
   end

   assign bus.OUT_freeCount = free_cnt;

`ifdef TAG_FREE_CHECK_EN
   logic dbl_free;
   logic bad_take;
   logic dup_take;
   logic err_q;

   always_comb begin
      dbl_free = 1'b0;
      dup_take = 1'b0;
      if (commit_en && !bus.IN_mispred) begin
         for (int s = 0; s < NUM_COMMIT; s++) begin
            if (bus.IN_commitValid[s] && !is_special(bus.IN_commitPrevTags[s]) &&
                spec_free[bus.IN_commitPrevTags[s][TAG_IDX_W-1:0]]) begin
               dbl_free = 1'b1;
            end
         end
      end
      bad_take = (|(bus.IN_issueReq & ~offer_valid)) && !bus.IN_mispred;
      for (int i = 0; i < NUM_ISSUE; i++) begin
         for (int j = i + 1; j < NUM_ISSUE; j++) begin
            if (take[i] && take[j] && (offer_idx[i] == offer_idx[j])) begin
               dup_take = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (dbl_free || bad_take || dup_take) begin
         err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!dbl_free);
         assert (!bad_take);
         assert (!dup_take);
      end
   end

   assign bus.OUT_err = err_q;
`else
   assign bus.OUT_err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// tb/tb_tag_free_list.sv - self-checking bench for tag_free_list against a bitmap reference model
module tb_tag_free_list;
   import tag_free_list_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tag_free_list_if bus();

   tag_free_list dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   bit spec_m [NUM_TAGS];
   bit com_m  [NUM_TAGS];

   function automatic int model_count();
      int c;
      c = 0;
      for (int t = 0; t < NUM_TAGS; t++) c += int'(spec_m[t]);
      return c;
   endfunction

   function automatic int model_offer(int k);
      int seen;
      seen = 0;
      for (int t = 0; t < NUM_TAGS; t++) begin
         if (spec_m[t]) begin
            if (seen == k) return t;
            seen++;
         end
      end
      return -1;
   endfunction

   task automatic idle_inputs();
      bus.IN_mispred        = 1'b0;
      bus.IN_mispredFlush   = 1'b0;
      bus.IN_issueReq       = '0;
      bus.IN_commitValid    = '0;
      bus.IN_commitTags     = '0;
      bus.IN_commitPrevTags = '0;
   endtask

   // Applies one clock of the free-list rules to the model, then advances past the edge
   task automatic cycle();
      bit ns [NUM_TAGS];
      bit nc [NUM_TAGS];
      int off;
      nc = com_m;
      ns = spec_m;
      if (!bus.IN_mispredFlush) begin
         for (int s = 0; s < NUM_COMMIT; s++) begin
            if (bus.IN_commitValid[s]) begin
               if (!bus.IN_commitTags[s][TAG_SIZE-1]) nc[bus.IN_commitTags[s][TAG_IDX_W-1:0]] = 1'b0;
               if (!bus.IN_commitPrevTags[s][TAG_SIZE-1]) nc[bus.IN_commitPrevTags[s][TAG_IDX_W-1:0]] = 1'b1;
            end
         end
      end
      if (bus.IN_mispred) begin
         ns = nc;
      end else begin
         for (int i = 0; i < NUM_ISSUE; i++) begin
            off = model_offer(i);
            if (bus.IN_issueReq[i] && off >= 0) ns[off] = 1'b0;
         end
         for (int s = 0; s < NUM_COMMIT; s++) begin
            if (bus.IN_commitValid[s] && bus.IN_mispredFlush && !bus.IN_commitTags[s][TAG_SIZE-1])
               ns[bus.IN_commitTags[s][TAG_IDX_W-1:0]] = 1'b0;
         end
         for (int s = 0; s < NUM_COMMIT; s++) begin
            if (bus.IN_commitValid[s] && !bus.IN_mispredFlush && !bus.IN_commitPrevTags[s][TAG_SIZE-1])
               ns[bus.IN_commitPrevTags[s][TAG_IDX_W-1:0]] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int t = 0; t < NUM_TAGS; t++) begin
            spec_m[t] = 1'b1;
            com_m[t]  = 1'b1;
         end
      end else begin
         spec_m = ns;
         com_m  = nc;
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < NUM_ISSUE; i++) begin
         checks++;
         if (bus.OUT_issueValid[i] !== 1'b1 || bus.OUT_issueTags[i] !== tag_t'(i)) begin
            failures++;
            $display("FAIL reset_offer port%0d: got valid=%0b tag=%0d expected valid=1 tag=%0d",
                     i, bus.OUT_issueValid[i], bus.OUT_issueTags[i], i);
         end
      end
      checks++;
      if (bus.OUT_freeCount !== tag_t'(64)) begin
         failures++;
         $display("FAIL reset_count: got %0d expected 64", bus.OUT_freeCount);
      end
   endtask

   task automatic test_exhaust();
      for (int k = 0; k < 16; k++) begin
         bus.IN_issueReq = 4'hF;
         cycle();
         checks++;
         if (bus.OUT_freeCount !== tag_t'(60 - 4 * k)) begin
            failures++;
            $display("FAIL exhaust_count step%0d: got %0d expected %0d", k, bus.OUT_freeCount, 60 - 4 * k);
         end
      end
      idle_inputs();
      checks++;
      if (bus.OUT_issueValid !== 4'b0000) begin
         failures++;
         $display("FAIL exhaust_empty: got valid=%b expected 0000", bus.OUT_issueValid);
      end
      bus.IN_commitValid[0]    = 1'b1;
      bus.IN_commitTags[0]     = TAG_ZERO;
      bus.IN_commitPrevTags[0] = tag_t'(5);
      #1;
      checks++;
      if (bus.OUT_issueValid[0] !== 1'b0) begin
         failures++;
         $display("FAIL free_same_cycle: got valid=%0b expected 0", bus.OUT_issueValid[0]);
      end
      cycle();
      idle_inputs();
      checks++;
      if (bus.OUT_issueValid !== 4'b0001 || bus.OUT_issueTags[0] !== tag_t'(5) || bus.OUT_freeCount !== tag_t'(1)) begin
         failures++;
         $display("FAIL free_reoffer: got valid=%b tag=%0d count=%0d expected valid=0001 tag=5 count=1",
                  bus.OUT_issueValid, bus.OUT_issueTags[0], bus.OUT_freeCount);
      end
   endtask

   task automatic test_mispred_restore();
      do_reset();
      bus.IN_issueReq = 4'hF;
      cycle();
      cycle();
      idle_inputs();
      for (int s = 0; s < NUM_COMMIT; s++) begin
         bus.IN_commitValid[s]    = 1'b1;
         bus.IN_commitTags[s]     = tag_t'(s);
         bus.IN_commitPrevTags[s] = TAG_ZERO | tag_t'(s);
      end
      cycle();
      idle_inputs();
      bus.IN_mispred = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (bus.OUT_issueTags[0] !== tag_t'(4) || bus.OUT_issueTags[3] !== tag_t'(7) || bus.OUT_freeCount !== tag_t'(60)) begin
         failures++;
         $display("FAIL mispred_restore: got tag0=%0d tag3=%0d count=%0d expected tag0=4 tag3=7 count=60",
                  bus.OUT_issueTags[0], bus.OUT_issueTags[3], bus.OUT_freeCount);
      end
   endtask

   task automatic test_mispred_concurrent();
      bus.IN_issueReq = 4'hF;
      cycle();
      cycle();
      idle_inputs();
      bus.IN_commitValid[0]    = 1'b1;
      bus.IN_commitTags[0]     = tag_t'(9);
      bus.IN_commitPrevTags[0] = TAG_ZERO;
      cycle();
      idle_inputs();
      bus.IN_mispred           = 1'b1;
      bus.IN_issueReq          = 4'hF;
      bus.IN_commitValid[0]    = 1'b1;
      bus.IN_commitTags[0]     = TAG_ZERO;
      bus.IN_commitPrevTags[0] = tag_t'(9);
      cycle();
      idle_inputs();
      checks++;
      if (bus.OUT_issueValid !== 4'hF || bus.OUT_issueTags[0] !== tag_t'(4) || bus.OUT_freeCount !== tag_t'(60)) begin
         failures++;
         $display("FAIL mispred_concurrent: got valid=%b tag0=%0d count=%0d expected valid=1111 tag0=4 count=60",
                  bus.OUT_issueValid, bus.OUT_issueTags[0], bus.OUT_freeCount);
      end
   endtask

   task automatic test_replay();
      bus.IN_mispredFlush      = 1'b1;
      bus.IN_commitValid       = 4'b0011;
      bus.IN_commitTags[0]     = tag_t'(4);
      bus.IN_commitTags[1]     = tag_t'(5);
      bus.IN_commitPrevTags[0] = tag_t'(20);
      bus.IN_commitPrevTags[1] = tag_t'(21);
      cycle();
      idle_inputs();
      checks++;
      if (bus.OUT_issueTags[0] !== tag_t'(6) || bus.OUT_freeCount !== tag_t'(58)) begin
         failures++;
         $display("FAIL replay_clear: got tag0=%0d count=%0d expected tag0=6 count=58",
                  bus.OUT_issueTags[0], bus.OUT_freeCount);
      end
      bus.IN_mispred = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (bus.OUT_issueTags[0] !== tag_t'(4) || bus.OUT_freeCount !== tag_t'(60)) begin
         failures++;
         $display("FAIL replay_com_untouched: got tag0=%0d count=%0d expected tag0=4 count=60",
                  bus.OUT_issueTags[0], bus.OUT_freeCount);
      end
   endtask

   task automatic test_random();
      int   base;
      int   exp_off;
      for (int c = 0; c < 400; c++) begin
         bus.IN_issueReq     = 4'($urandom);
         bus.IN_mispred      = ($urandom_range(0, 19) == 0);
         bus.IN_mispredFlush = !bus.IN_mispred && ($urandom_range(0, 9) == 0);
         base = $urandom_range(0, NUM_TAGS - 1);
         for (int s = 0; s < NUM_COMMIT; s++) begin
            bus.IN_commitValid[s]    = ($urandom_range(0, 2) == 0);
            bus.IN_commitTags[s]     = ($urandom_range(0, 7) == 0) ? TAG_ZERO : tag_t'((base + s) % NUM_TAGS);
            bus.IN_commitPrevTags[s] = ($urandom_range(0, 7) == 0) ? TAG_ZERO : tag_t'((base + 4 + s) % NUM_TAGS);
         end
         cycle();
         for (int i = 0; i < NUM_ISSUE; i++) begin
            exp_off = model_offer(i);
            checks++;
            if (bus.OUT_issueValid[i] !== (exp_off >= 0) ||
                bus.OUT_issueTags[i] !== ((exp_off >= 0) ? tag_t'(exp_off) : tag_t'(0))) begin
               failures++;
               $display("FAIL random_offer cyc%0d port%0d: got valid=%0b tag=%0d expected valid=%0b tag=%0d",
                        c, i, bus.OUT_issueValid[i], bus.OUT_issueTags[i], exp_off >= 0, (exp_off >= 0) ? exp_off : 0);
            end
         end
         checks++;
         if (bus.OUT_freeCount !== tag_t'(model_count())) begin
            failures++;
            $display("FAIL random_count cyc%0d: got %0d expected %0d", c, bus.OUT_freeCount, model_count());
         end
`ifndef TAG_FREE_CHECK_EN
         checks++;
         if (bus.OUT_err !== 1'b0) begin
            failures++;
            $display("FAIL err_tied cyc%0d: got %0b expected 0", c, bus.OUT_err);
         end
`endif
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      bus.IN_issueReq       = 4'hF;
      bus.IN_mispred        = 1'b1;
      bus.IN_commitValid    = 4'hF;
      bus.IN_commitTags     = {tag_t'(0), tag_t'(1), tag_t'(2), tag_t'(3)};
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      idle_inputs();
      checks++;
      if (bus.OUT_issueValid !== 4'hF || bus.OUT_issueTags[0] !== tag_t'(0) ||
          bus.OUT_issueTags[3] !== tag_t'(3) || bus.OUT_freeCount !== tag_t'(64)) begin
         failures++;
         $display("FAIL reset_mid: got valid=%b tag0=%0d tag3=%0d count=%0d expected valid=1111 tag0=0 tag3=3 count=64",
                  bus.OUT_issueValid, bus.OUT_issueTags[0], bus.OUT_issueTags[3], bus.OUT_freeCount);
      end
   endtask

`ifdef TAG_FREE_CHECK_EN
   task automatic test_err();
      do_reset();
      bus.IN_issueReq = 4'hF;
      repeat (3) cycle();
      idle_inputs();
      bus.IN_commitValid[0]    = 1'b1;
      bus.IN_commitTags[0]     = TAG_ZERO;
      bus.IN_commitPrevTags[0] = tag_t'(10);
      cycle();
      checks++;
      if (bus.OUT_err !== 1'b0) begin
         failures++;
         $display("FAIL err_first_free: got %0b expected 0", bus.OUT_err);
      end
      cycle();
      idle_inputs();
      checks++;
      if (bus.OUT_err !== 1'b1) begin
         failures++;
         $display("FAIL err_double_free: got %0b expected 1", bus.OUT_err);
      end
      repeat (3) cycle();
      checks++;
      if (bus.OUT_err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: got %0b expected 1", bus.OUT_err);
      end
      do_reset();
      checks++;
      if (bus.OUT_err !== 1'b0) begin
         failures++;
         $display("FAIL err_reset: got %0b expected 0", bus.OUT_err);
      end
   endtask
`endif

   initial begin
      idle_inputs();
      rst = 1'b1;
      #1;
      test_reset();
      test_exhaust();
      test_mispred_restore();
      test_mispred_concurrent();
      test_replay();
      test_random();
      test_reset_mid();
`ifdef TAG_FREE_CHECK_EN
      test_err();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tag_free_list.md
Name: tag_free_list

Overview:
- Physical-tag allocator; the supply side of the rename table.
- Hands out free physical tags to the rename/issue stage, up to NUM_ISSUE per cycle.
- Reclaims the previous tags that commit returns once they are overwritten.
- Holds a speculative free bitmap and a committed free bitmap. On mispredict it restores speculative state from committed state, so tags allocated on the wrong path are reclaimed.

Parameters:
- NUM_ISSUE, 4, allocation ports per cycle
- NUM_COMMIT, 4, commit/free ports per cycle
- TAG_SIZE, 7, tag width. MSB=1 marks a special/immediate tag, which is never allocated or freed.
- NUM_TAGS, 1<<(TAG_SIZE-1), number of physical tags (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_mispred  in  1  mispredict: restore speculative state
- IN_mispredFlush  in  1  commit ports carry ROB replay, not true commits
- IN_issueReq  in  NUM_ISSUE x 1  consume tag on port i this cycle
- OUT_issueValid  out  NUM_ISSUE x 1  a free tag is offered on port i
- OUT_issueTags  out  NUM_ISSUE x TAG_SIZE  offered tag, MSB=0
- IN_commitValid  in  NUM_COMMIT x 1  commit slot valid
- IN_commitTags  in  NUM_COMMIT x TAG_SIZE  new tag made architectural
- IN_commitPrevTags  in  NUM_COMMIT x TAG_SIZE  previous tag for same reg (from rename table)
- OUT_freeCount  out  TAG_SIZE  number of speculatively free tags
- OUT_err  out  1  sticky integrity error (see Optional Feature)

Behaviour:
- State:
  - specFree[NUM_TAGS]: free for allocation.
  - comFree[NUM_TAGS]: free relative to committed map.
  - freeCnt: popcount mirror of specFree.
- Reset: specFree, comFree all 1; freeCnt=NUM_TAGS (saturated to the field width); OUT_err=0. Takes effect at the next edge and overrides everything, including a reset mid-operation.
- Offer (combinational, zero latency from state):
  - Port i gets the i-th lowest-index set bit of specFree.
  - OUT_issueValid[i]=0 and OUT_issueTags[i]=0 if fewer than i+1 bits are set.
  - Ports are filled lowest first.
- Consume: at posedge, port i with IN_issueReq && OUT_issueValid clears specFree[tag]. A request without valid is ignored and counts as an error.
- Commit, when !IN_mispredFlush and slot valid:
  - comFree[newTag]<=0 and comFree[prevTag]<=1 when the respective MSB=0.
  - specFree[prevTag]<=1.
  - A tag freed in cycle t is offered no earlier than t+1.
- Mispred (IN_mispred=1):
  - specFree <= comFree' (comFree including this cycle's commit updates).
  - Issue consumption this cycle is ignored.
  - Commit slots still update comFree.
- Replay (IN_mispredFlush=1, IN_mispred=0): valid slots clear specFree[newTag]. comFree is untouched. This re-applies pre-branch allocations.
- Update precedence within one cycle: rst > mispred restore > commit frees > replay/issue clears.
- freeCnt: recomputed each cycle as the popcount of next specFree. It is registered, so OUT_freeCount lags specFree by zero cycles (registered alongside it).
- Empty: all OUT_issueValid=0. The rename stage must stall; the block never stalls itself.
- Wrap: none. The bitmap is scanned fresh each cycle from index 0.

Optional Feature:
- Macro TAG_FREE_CHECK_EN.
- Defined: OUT_err is set sticky (cleared only by rst) on any of:
  - freeing a tag whose specFree bit is already 1 (outside mispred);
  - consuming with OUT_issueValid=0;
  - a duplicate tag across issue ports in one cycle.
  - Simulation assertions fire on the same conditions.
- Undefined: OUT_err tied 0; no check logic.

Decomposition:
- Shared package: Tag typedef, TAG_SIZE, NUM_TAGS, TAG_ZERO (special zero tag, MSB=1).
- One sub-module, tag_prio_enc: finds the first NUM_ISSUE set bits of a NUM_TAGS vector and returns indices and valids. Purely combinational.

Test Plan:
- Reset, then read ports -> tags 0,1,2,3 valid; OUT_freeCount=64.
- Consume all 4 ports for 16 cycles -> 64 allocated, all OUT_issueValid=0, count 0. Commit prevTag=5 -> next cycle port0 offers 5, count 1.
- Allocate tags 0..7, commit newTags 0..3 with prevTags special (MSB=1), then assert IN_mispred -> tags 4..7 free again, count 60, port0 offers 4.
- Mispred with concurrent commit prevTag=9 and issueReq -> specFree equals comFree with 9 free; issue consumption dropped.
- Replay cycle with IN_mispredFlush, newTags 4,5 -> specFree[4],[5] cleared; comFree unchanged.
- TAG_FREE_CHECK_EN: free tag 10 twice -> OUT_err=1 next cycle and remains 1 until rst.
